// File: rtl/serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM state encodings.
package serial_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/nibble_adder_slice.sv
// Combinational 4-bit adder slice used once per clock by nibble_serial_adder.
// Ports:
//   a, b   : 4-bit addends
//   cin    : carry into bit 0
//   sum4   : 4-bit sum
//   cout   : carry out of bit 3
//   c3     : carry into bit 3 (only with NIBBLE_SERIAL_ADDER_OVF_EN defined)
module nibble_adder_slice
  import serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic                c3,
`endif
  output logic [NIBBLE_W-1:0] sum4,
  output logic                cout
);

  assign {cout, sum4} = (NIBBLE_W+1)'(a) + (NIBBLE_W+1)'(b) + (NIBBLE_W+1)'(cin);

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  // Carry into the MSB, from adding the lower three bits only.
  logic [NIBBLE_W-1:0] low_sum;
  assign low_sum = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b[NIBBLE_W-2:0]} + NIBBLE_W'(cin);
  assign c3      = low_sum[NIBBLE_W-1];
`endif

endmodule : nibble_adder_slice

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor, one nibble per clock through a single slice.
// Optional signed-overflow output enabled by macro NIBBLE_SERIAL_ADDER_OVF_EN
// (ovf tied to 0 when undefined).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : request, accepted only in IDLE
//   a, b, cin, sub  : operands, latched on the accepting edge
//   busy            : high while in RUN
//   done            : one-cycle pulse, result valid
//   sum, cout, ovf  : result, held until the next operation completes
module nibble_serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W = $clog2(NIB) + 1;

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic [WIDTH-1:0]    res_next;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic slice_c3;
  logic ovf_q, ovf_d;
`endif

  nibble_adder_slice u_slice (
    .a    (a_sr_q[NIBBLE_W-1:0]),
    .b    (b_sr_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    .c3   (slice_c3),
`endif
    .sum4 (slice_sum),
    .cout (slice_cout)
  );

  // Slice result enters at the MSB end so the final nibble lands on top.
  assign res_next = (res_q >> NIBBLE_W) | (WIDTH'(slice_sum) << (WIDTH - NIBBLE_W));

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    carry_d = carry_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_sr_d  = a;
          b_sr_d  = sub ? ~b : b;
          // Subtraction is A + ~B + 1, with borrow-in removing the +1.
          carry_d = cin ^ sub;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> NIBBLE_W;
        b_sr_d  = b_sr_q >> NIBBLE_W;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        res_d   = res_next;
        busy_d  = 1'b1;
        if (cnt_q == CNT_W'(NIB - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = res_next;
          cout_d  = slice_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          ovf_d   = slice_c3 ^ slice_cout;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : nibble_serial_adder
